// File: rtl/seq_stream_decoder.sv
// Receive-side checker for the 2/5/6/4/3 sequence generator: validates each
// symbol transition, recovers the branch input `a`, tracks lock and counts errors.
module seq_stream_decoder #(
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sym,
  input  logic             sym_valid,
  output logic             a_out,
  output logic             a_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [2:0]       prev, prev_n;
  logic             prev_valid, prev_valid_n;
  logic [3:0]       lock_cnt, lock_cnt_n;
  logic             a_out_n, a_valid_n, err_pulse_n;
  logic [CNT_W-1:0] err_count_n;

  logic code_ok, trans_ok, is_branch, dec_a;

  always_comb begin
    code_ok = 1'b0;
    case (sym)
      3'd2, 3'd5, 3'd6, 3'd4, 3'd3: code_ok = 1'b1;
      default:                      code_ok = 1'b0;
    endcase
  end

  // Legal transition graph of the generator; branch edges reveal `a`.
  always_comb begin
    trans_ok  = 1'b0;
    is_branch = 1'b0;
    dec_a     = 1'b0;
    case ({prev, sym})
      6'o25: trans_ok = 1'b1;
      6'o53: begin trans_ok = 1'b1; is_branch = 1'b1; dec_a = 1'b1; end
      6'o56: begin trans_ok = 1'b1; is_branch = 1'b1; dec_a = 1'b0; end
      6'o36: trans_ok = 1'b1;
      6'o64: trans_ok = 1'b1;
      6'o45: begin trans_ok = 1'b1; is_branch = 1'b1; dec_a = 1'b1; end
      6'o42: begin trans_ok = 1'b1; is_branch = 1'b1; dec_a = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_n      = state;
    prev_n       = prev;
    prev_valid_n = prev_valid;
    lock_cnt_n   = lock_cnt;
    a_out_n      = a_out;
    a_valid_n    = 1'b0;
    err_pulse_n  = 1'b0;
    err_count_n  = err_count;

    if (sym_valid) begin
      if (!prev_valid) begin
        if (code_ok) begin
          prev_n       = sym;
          prev_valid_n = 1'b1;
        end
      end else if (trans_ok) begin
        prev_n = sym;
        if (is_branch) begin
          a_out_n   = dec_a;
          a_valid_n = 1'b1;
        end
        if (state == HUNT) begin
          lock_cnt_n = lock_cnt + 4'd1;
          if (lock_cnt + 4'd1 == 4'(LOCK_LEN))
            state_n = LOCKED;
        end
      end else begin
        // Any break restarts the lock search; only a locked link reports it.
        lock_cnt_n = 4'd0;
        if (state == LOCKED) begin
          state_n     = HUNT;
          err_pulse_n = 1'b1;
          if (err_count != {CNT_W{1'b1}})
            err_count_n = err_count + CNT_W'(1);
        end
        if (code_ok)
          prev_n = sym;
        else
          prev_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      prev       <= 3'd0;
      prev_valid <= 1'b0;
      lock_cnt   <= 4'd0;
      a_out      <= 1'b0;
      a_valid    <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      prev_valid <= prev_valid_n;
      lock_cnt   <= lock_cnt_n;
      a_out      <= a_out_n;
      a_valid    <= a_valid_n;
      err_pulse  <= err_pulse_n;
      err_count  <= err_count_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
